// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the digit UART reporter.
package uart_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;

   localparam int unsigned IDX_W = 2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_SEND    = 3'd3,
      ST_NEXT    = 3'd4
   } state_e;

   // Decimal digit to ASCII; anything above 9 reports as '?'.
   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_QMARK;
   endfunction

endpackage

// File: rtl/digit_uart_reporter_if.sv
// Host-facing bundle: start request, RAM read port and UART status.
interface digit_uart_reporter_if;
   logic       start;
   logic       rd_addr;
   logic [7:0] rd_data;
   logic       uart_tx;
   logic       busy;
   logic       done;

   modport slave  (input start, input rd_data,
                   output rd_addr, output uart_tx, output busy, output done);
   modport master (output start, output rd_data,
                   input rd_addr, input uart_tx, input busy, input done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serializer. tx_done strobes in the second-to-last stop-bit cycle so the
// caller can chain the next frame with no idle gap (needs CLKS_PER_BIT >= 2).
module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [3:0] BIT_LAST_DATA = 4'd8;
   localparam logic [3:0] BIT_STOP      = 4'd9;

   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [7:0]        shreg_q, shreg_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              in_stop_c, last_c;

   assign in_stop_c = busy_q && (bit_q == BIT_STOP);
   assign last_c    = in_stop_c && (baud_q == BAUD_LAST);
   assign tx_done   = in_stop_c && (baud_q == BAUD_PRE);
   assign tx        = tx_q;
   assign tx_busy   = busy_q;

   // A new frame may load while idle or on the final stop-bit cycle.
   always_comb begin
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      if (tx_start && (!busy_q || last_c)) begin
         busy_d  = 1'b1;
         baud_d  = '0;
         bit_d   = 4'd0;
         shreg_d = tx_data;
         tx_d    = 1'b0;
      end else if (busy_q) begin
         if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == BIT_STOP) begin
               busy_d = 1'b0;
            end else begin
               bit_d = bit_q + 4'd1;
               if (bit_q == BIT_LAST_DATA) begin
                  tx_d = 1'b1;
               end else begin
                  tx_d    = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end
         end else begin
            baud_d = baud_q + BAUD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_q  <= '0;
         bit_q   <= 4'd0;
         shreg_q <= 8'h00;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: rtl/digit_uart_reporter.sv
// Reads the predicted digit from RAM and reports it as ASCII over UART,
// optionally followed by CR LF.
module digit_uart_reporter
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned BAUD_RATE    = 115200,
   parameter bit          SEND_NEWLINE = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   digit_uart_reporter_if.slave bus
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tx_start_c;
   logic [7:0]       tx_data_c;
   logic             tx_c, tx_busy_c, tx_done_c;
   logic             unused_c;

   assign bus.rd_addr = 1'b0;
   assign bus.uart_tx = tx_c;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign unused_c    = &{1'b0, bus.rd_data[7:4]};

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .tx_start(tx_start_c),
      .tx_data (tx_data_c),
      .tx      (tx_c),
      .tx_busy (tx_busy_c),
      .tx_done (tx_done_c)
   );

   // The digit byte goes straight from the RAM port into the serializer.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tx_start_c = 1'b0;
      tx_data_c  = ASCII_CR;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RD_ADDR;
               busy_d  = 1'b1;
            end
         end
         ST_RD_ADDR: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            tx_start_c = 1'b1;
            tx_data_c  = digit_to_ascii(bus.rd_data[3:0]);
            idx_d      = '0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (tx_done_c || !tx_busy_c) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (SEND_NEWLINE && (idx_q < IDX_LAST)) begin
               tx_start_c = 1'b1;
               tx_data_c  = (idx_q == IDX_W'(0)) ? ASCII_CR : ASCII_LF;
               idx_d      = idx_q + IDX_W'(1);
               state_d    = ST_SEND;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_digit_uart_reporter.sv
// Bench for digit_uart_reporter: CR/LF and digit-only instances, each fed by
// a one-cycle-latency RAM model.
module tb_digit_uart_reporter;

   localparam int MAXC = 400;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   digit_uart_reporter_if if1 ();
   digit_uart_reporter_if if0 ();

   digit_uart_reporter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .SEND_NEWLINE(1'b1))
      dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   digit_uart_reporter #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .SEND_NEWLINE(1'b0))
      dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

   logic [7:0] mem1 [2];
   logic [7:0] mem0 [2];
   logic       we1, we0;
   logic [7:0] wd1, wd0;

   // Read-before-write RAM: a write on the read edge is not seen.
   always_ff @(posedge clk) begin
      if (we1) mem1[0] <= wd1;
      if (we0) mem0[0] <= wd0;
      if1.rd_data <= mem1[if1.rd_addr];
      if0.rd_data <= mem0[if0.rd_addr];
   end

   int errors = 0;
   int checks = 0;

   logic tx_h   [0:MAXC];
   logic busy_h [0:MAXC];
   logic done_h [0:MAXC];

   typedef struct {
      bit         nl;
      bit         init;
      logic [7:0] ram;
      int         ra;
      int         rb;
      int         wc;
      logic [7:0] wv;
      logic [7:0] exp0;
      int         exp_done;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic get_tx(input bit nl);
      return nl ? if1.uart_tx : if0.uart_tx;
   endfunction
   function automatic logic get_busy(input bit nl);
      return nl ? if1.busy : if0.busy;
   endfunction
   function automatic logic get_done(input bit nl);
      return nl ? if1.done : if0.done;
   endfunction

   task automatic drive(input bit nl, input logic s, input logic w, input logic [7:0] d);
      if (nl) begin
         if1.start = s; we1 = w; wd1 = d;
      end else begin
         if0.start = s; we0 = w; wd0 = d;
      end
   endtask

   task automatic ram_write(input bit nl, input logic [7:0] v);
      drive(nl, 1'b0, 1'b1, v);
      @(negedge clk);
      drive(nl, 1'b0, 1'b0, v);
   endtask

   // start is sampled at edge 0; history index n is the value seen in cycle n.
   task automatic run(input bit nl, input int ra, input int rb, input int wc,
                      input logic [7:0] wv, input int rc, input int ncyc);
      drive(nl, 1'b1, 1'b0, wv);
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         tx_h[n]   = get_tx(nl);
         busy_h[n] = get_busy(nl);
         done_h[n] = get_done(nl);
         drive(nl, (n == ra) || (n == rb), n == wc, wv);
         rst = (n == rc);
      end
      drive(nl, 1'b0, 1'b0, wv);
      rst = 1'b0;
   endtask

   // Mid-bit samples of the frame whose start bit begins in cycle base.
   function automatic logic [9:0] frame_at(input int base);
      logic [9:0] f;
      for (int i = 0; i < 10; i++) f[i] = tx_h[base + 10*i + 5];
      return f;
   endfunction

   task automatic check_report(input string tag, input bit nl, input logic [7:0] exp0,
                               input int exp_done);
      int first = -1;
      int nd = 0;
      int nb = 0;
      chk({tag, " idle_pre"}, 32'({tx_h[1], tx_h[2]}), 32'b11);
      chk({tag, " byte0"}, 32'(frame_at(3)), 32'({1'b1, exp0, 1'b0}));
      if (nl) begin
         chk({tag, " byte1"}, 32'(frame_at(103)), 32'({1'b1, 8'h0D, 1'b0}));
         chk({tag, " byte2"}, 32'(frame_at(203)), 32'({1'b1, 8'h0A, 1'b0}));
      end
      for (int n = 1; n <= exp_done + 5; n++) begin
         if (done_h[n] === 1'b1) begin
            nd++;
            if (first < 0) first = n;
         end
         if (n < exp_done && busy_h[n] === 1'b1) nb++;
      end
      chk({tag, " done_cycle"}, 32'(first), 32'(exp_done));
      chk({tag, " done_pulses"}, 32'(nd), 32'd1);
      chk({tag, " busy_span"}, 32'(nb), 32'(exp_done - 1));
      chk({tag, " busy_end"}, 32'(busy_h[exp_done]), 32'd0);
      chk({tag, " tx_idle_end"}, 32'(tx_h[exp_done]), 32'd1);
   endtask

   task automatic wait_done(input bit nl, input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (get_done(nl) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, " drain_done"}, 32'(seen), 32'd1);
   endtask

   initial begin
      int nones;
      int ndone;
      vecs[0] = '{1'b1, 1'b1, 8'h07, -1, -1, -1, 8'h00, 8'h37, 303};
      vecs[1] = '{1'b1, 1'b1, 8'h0C, -1, -1, -1, 8'h00, 8'h3F, 303};
      vecs[2] = '{1'b1, 1'b1, 8'hF3, -1, -1, -1, 8'h00, 8'h33, 303};
      vecs[3] = '{1'b0, 1'b1, 8'h00, -1, -1, -1, 8'h00, 8'h30, 103};
      vecs[4] = '{1'b0, 1'b1, 8'h0A, -1, -1, -1, 8'h00, 8'h3F, 103};
      vecs[5] = '{1'b1, 1'b1, 8'h07, 50, 200, -1, 8'h00, 8'h37, 303};
      vecs[6] = '{1'b1, 1'b1, 8'h05, -1, -1, 1, 8'h09, 8'h35, 303};
      vecs[7] = '{1'b1, 1'b1, 8'h05, -1, -1, 150, 8'h09, 8'h35, 303};
      vecs[8] = '{1'b1, 1'b0, 8'h00, -1, -1, -1, 8'h00, 8'h39, 303};

      rst = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset uart_tx", 32'({if1.uart_tx, if0.uart_tx}), 32'b11);
      chk("reset busy", 32'({if1.busy, if0.busy}), 32'b00);
      chk("reset done", 32'({if1.done, if0.done}), 32'b00);
      chk("reset rd_addr", 32'({if1.rd_addr, if0.rd_addr}), 32'b00);

      foreach (vecs[i]) begin
         if (vecs[i].init) ram_write(vecs[i].nl, vecs[i].ram);
         run(vecs[i].nl, vecs[i].ra, vecs[i].rb, vecs[i].wc, vecs[i].wv, -1,
             vecs[i].exp_done + 5);
         check_report($sformatf("v%0d", i), vecs[i].nl, vecs[i].exp0, vecs[i].exp_done);
      end

      // start in the done cycle is accepted and begins a new report.
      ram_write(1'b0, 8'h04);
      run(1'b0, 103, -1, -1, 8'h00, -1, 110);
      check_report("dcy", 1'b0, 8'h34, 103);
      chk("dcy rebusy", 32'(busy_h[104]), 32'd1);
      chk("dcy gap", 32'(tx_h[105]), 32'd1);
      chk("dcy restart_bit", 32'(tx_h[108]), 32'd0);
      wait_done(1'b0, "dcy");

      // Reset mid data bits aborts the frame cleanly.
      run(1'b1, -1, -1, -1, 8'h00, 40, 70);
      chk("rst tx", 32'(tx_h[41]), 32'd1);
      chk("rst busy", 32'(busy_h[41]), 32'd0);
      nones = 0;
      ndone = 0;
      for (int n = 1; n <= 70; n++) begin
         if (done_h[n] === 1'b1) ndone++;
         if (n > 40 && tx_h[n] === 1'b1) nones++;
      end
      chk("rst no_done", 32'(ndone), 32'd0);
      chk("rst line_idle", 32'(nones), 32'd30);
      run(1'b1, -1, -1, -1, 8'h00, -1, 308);
      check_report("post_rst", 1'b1, 8'h39, 303);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
